// File: rtl/cordic_if.sv
// cordic_if: request/result handshake bundle for cordic_core.
// master drives operands and out_ready; slave returns results.
interface cordic_if #(
  parameter int DW = 16
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode;
  logic signed [DW-1:0] x_in;
  logic signed [DW-1:0] y_in;
  logic signed [DW-1:0] z_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] x_out;
  logic signed [DW-1:0] y_out;
  logic signed [DW-1:0] z_out;
  logic                 busy;

  modport master (
    output in_valid, mode, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, busy
  );

  modport slave (
    input  in_valid, mode, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, busy
  );
endinterface

// File: rtl/cordic_core.sv
// cordic_core: iterative CORDIC (rotation/vectoring), binary-angle z.
// Define CORDIC_GAIN_COMP_EN to add a one-cycle gain compensation stage.
module cordic_core #(
  parameter int DW   = 16,
  parameter int ITER = 14,
  parameter int GW   = 4
) (
  input logic     clk,
  input logic     rst,
  cordic_if.slave io
);
  localparam int W  = DW + GW + 2;
  localparam int AW = DW + GW;
  localparam int SH = 32 - AW;

  localparam logic [32:0] ARND = 33'((64'd1 << SH) >> 1);
  localparam logic signed [W-1:0] PI = W'(64'd1 << (AW - 1));
  localparam logic signed [W-1:0] RH = W'(64'd1 << (GW - 1));
  localparam logic signed [DW-1:0] QP = DW'(64'd1 << (DW - 2));

  // atan(2^-i)/pi scaled by 2^31, rescaled to the internal angle LSB
  localparam logic [31:0] ATAN_T [32] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  function automatic logic signed [W-1:0] atan_lut(input logic [4:0] k);
    return W'(({1'b0, ATAN_T[k]} + ARND) >> SH);
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [W-1:0] v);
    if (&v[W-1:DW-1] || ~|v[W-1:DW-1]) return v[DW-1:0];
    return v[W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, RUN, COMP, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif

  state_t state_q, state_d;
  logic [4:0] i_q;
  logic mode_q;
  logic signed [W-1:0] x_q, y_q, z_q;
  logic signed [W-1:0] xe, ye, ze, xa, ya, za;
  logic [AW-1:0] zf;
  logic signed [W-1:0] xs, ys, atan_c, x_n, y_n, z_n;
  logic d_pos;

  always_comb begin
    xe = {{2{io.x_in[DW-1]}}, io.x_in, {GW{1'b0}}};
    ye = {{2{io.y_in[DW-1]}}, io.y_in, {GW{1'b0}}};
    ze = {{2{io.z_in[DW-1]}}, io.z_in, {GW{1'b0}}};
    // subtracting pi modulo 2^AW only flips the angle MSB
    zf = {~io.z_in[DW-1], io.z_in[DW-2:0], {GW{1'b0}}};
    xa = xe;
    ya = ye;
    za = ze;
    if (io.mode) begin
      if (io.x_in[DW-1]) begin
        xa = -xe;
        ya = -ye;
        za = PI;
      end
    end else if (io.z_in > QP || io.z_in < -QP) begin
      xa = -xe;
      ya = -ye;
      za = {{2{zf[AW-1]}}, zf};
    end
  end

  always_comb begin
    xs     = x_q >>> i_q;
    ys     = y_q >>> i_q;
    atan_c = atan_lut(i_q);
    d_pos  = mode_q ? y_q[W-1] : ~z_q[W-1];
    if (d_pos) begin
      x_n = x_q - ys;
      y_n = y_q + xs;
      z_n = z_q - atan_c;
    end else begin
      x_n = x_q + ys;
      y_n = y_q - xs;
      z_n = z_q + atan_c;
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [W+DW-1:0] KG =
    (W+DW)'($rtoi(0.607252935 * (2.0 ** (DW - 1)) + 0.5));
  localparam logic signed [W+DW-1:0] RG = (W+DW)'(64'd1 << (DW - 2));
  logic signed [W-1:0] xg, yg;

  always_comb begin
    xg = W'(((W+DW)'(x_q) * KG + RG) >>> (DW - 1));
    yg = W'(((W+DW)'(y_q) * KG + RG) >>> (DW - 1));
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (io.in_valid) state_d = RUN;
`ifdef CORDIC_GAIN_COMP_EN
      RUN:  if (i_q == 5'(ITER - 1)) state_d = COMP;
      COMP: state_d = DONE;
`else
      RUN:  if (i_q == 5'(ITER - 1)) state_d = DONE;
`endif
      DONE: if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      mode_q <= 1'b0;
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (io.in_valid) begin
          i_q    <= '0;
          mode_q <= io.mode;
          x_q    <= xa;
          y_q    <= ya;
          z_q    <= za;
        end
        RUN: begin
          i_q <= i_q + 5'd1;
          x_q <= x_n;
          y_q <= y_n;
          z_q <= z_n;
        end
`ifdef CORDIC_GAIN_COMP_EN
        COMP: begin
          x_q <= xg;
          y_q <= yg;
        end
`endif
        default: ;
      endcase
    end
  end

  assign io.in_ready  = (state_q == IDLE);
  assign io.busy      = (state_q != IDLE);
  assign io.out_valid = (state_q == DONE);

  always_comb begin
    io.x_out = '0;
    io.y_out = '0;
    io.z_out = '0;
    if (state_q == DONE) begin
      io.x_out = sat((x_q + RH) >>> GW);
      io.y_out = sat((y_q + RH) >>> GW);
      io.z_out = DW'((z_q + RH) >>> GW);
    end
  end
endmodule

// File: tb/tb_cordic_core.sv
// tb_cordic_core: directed vectors with hand-computed expectations.
// Gain-dependent expectations follow CORDIC_GAIN_COMP_EN.
module tb_cordic_core;
  localparam int DW   = 16;
  localparam int ITER = 14;
  localparam int GW   = 4;
`ifdef CORDIC_GAIN_COMP_EN
  localparam int LAT = ITER + 1;
  localparam int XA  = 32767;
  localparam int VM  = 14142;
  localparam int V1  = 10000;
`else
  localparam int LAT = ITER;
  localparam int XA  = 19898;
  localparam int VM  = 23288;
  localparam int V1  = 16468;
`endif
  localparam int XR = 23170;

  logic clk = 1'b0;
  logic rst;
  int vec = 0;
  int bad = 0;

  cordic_if #(.DW(DW)) io ();

  cordic_core #(.DW(DW), .ITER(ITER), .GW(GW)) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tol(input string tag, input int obs, input int exp,
                     input int t);
    logic signed [15:0] d;
    logic ok;
    d  = 16'(obs - exp);
    ok = (int'(d) <= t) && (int'(d) >= -t);
    vec++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+/-%0d", tag, obs, exp, t);
    end
  endtask

  task automatic start_op(input string tag, input bit m, input int x,
                          input int y, input int z);
    int n;
    n = 0;
    while (io.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".idle"}, int'(io.in_ready), 1);
    io.mode     = m;
    io.x_in     = DW'(x);
    io.y_in     = DW'(y);
    io.z_in     = DW'(z);
    io.in_valid = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (io.out_valid !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, ".lat"}, n, LAT);
  endtask

  task automatic consume(input string tag);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1;
    io.out_ready = 1'b0;
    chk({tag, ".ovlo"}, int'(io.out_valid), 0);
    chk({tag, ".rdy"}, int'(io.in_ready), 1);
  endtask

  task automatic op(input string tag, input bit m, input int x, input int y,
                    input int z, input int ex, input int ey, input int ez,
                    input int txy, input int tz);
    start_op(tag, m, x, y, z);
    wait_done(tag);
    tol({tag, ".x"}, int'(io.x_out), ex, txy);
    tol({tag, ".y"}, int'(io.y_out), ey, txy);
    tol({tag, ".z"}, int'(io.z_out), ez, tz);
    consume(tag);
  endtask

  initial begin
    int seen;
    rst          = 1'b1;
    io.in_valid  = 1'b0;
    io.out_ready = 1'b0;
    io.mode      = 1'b0;
    io.x_in      = '0;
    io.y_in      = '0;
    io.z_in      = '0;
    #12;
    chk("rst.in_ready", int'(io.in_ready), 1);
    chk("rst.busy", int'(io.busy), 0);
    chk("rst.out_valid", int'(io.out_valid), 0);
    chk("rst.x_out", int'(io.x_out), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef CORDIC_GAIN_COMP_EN
    op("gc45", 1'b0, 16384, 0, 'h2000, 11585, 11585, 0, 4, 2);
`endif
    op("rot45", 1'b0, XA, 0, 'h2000, XR, XR, 0, 4, 2);
    op("rotm45", 1'b0, XA, 0, 'hE000, XR, -XR, 0, 6, 2);
    op("rotm135", 1'b0, XA, 0, 'hA000, -XR, -XR, 0, 4, 2);
    op("rot135", 1'b0, XA, 0, 'h6000, -XR, XR, 0, 6, 2);
    op("rot90", 1'b0, XA, 0, 'h4000, 0, 32767, 0, 8, 2);
    op("vec45", 1'b1, 10000, 10000, 0, VM, 0, 'h2000, 8, 2);
    op("vecm45", 1'b1, 10000, -10000, 0, VM, 0, -'h2000, 8, 2);
    op("vec180", 1'b1, -10000, 0, 0, V1, 0, -'h8000, 8, 2);
`ifndef CORDIC_GAIN_COMP_EN
    start_op("satp", 1'b0, 32767, 0, 0);
    wait_done("satp");
    chk("satp.x", int'(io.x_out), 32767);
    consume("satp");
    start_op("satn", 1'b0, -32768, 0, 0);
    wait_done("satn");
    chk("satn.x", int'(io.x_out), -32768);
    consume("satn");
`endif

    start_op("stall", 1'b0, XA, 0, 'h2000);
    wait_done("stall");
    for (int k = 0; k < 5; k++) begin
      io.in_valid = 1'b1;
      io.mode     = 1'b1;
      io.x_in     = 16'sd1234;
      io.z_in     = 16'sd777;
      @(posedge clk);
      #1;
      chk("stall.in_ready", int'(io.in_ready), 0);
      chk("stall.out_valid", int'(io.out_valid), 1);
      tol("stall.x", int'(io.x_out), XR, 4);
    end
    io.in_valid = 1'b0;
    consume("stall");
    @(posedge clk);
    #1;
    chk("stall.nobusy", int'(io.busy), 0);

    start_op("abort", 1'b0, XA, 0, 'h2000);
    repeat (7) @(posedge clk);
    #1;
    chk("abort.busy_run", int'(io.busy), 1);
    rst = 1'b1;
    #1;
    chk("abort.in_ready", int'(io.in_ready), 1);
    chk("abort.busy", int'(io.busy), 0);
    chk("abort.out_valid", int'(io.out_valid), 0);
    chk("abort.x_out", int'(io.x_out), 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (io.out_valid === 1'b1) seen++;
    end
    chk("abort.no_result", seen, 0);

    op("post", 1'b0, XA, 0, 'h2000, XR, XR, 0, 4, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
